// File: rtl/rl_md_pkg.sv
// Shared definitions for the RL force evaluation unit.
//   calc_id_width  : neighbour ID width = three cell coordinates + particle index
//   calc_cnt_width : width of a counter that can hold pipes*latency entries
//   popcount       : number of set bits in a vector (up to 32 bits)
//   tag_state_e    : reference-switch FSM states
package rl_md_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        ACK   = 2'd2,
        REL   = 2'd3
    } tag_state_e;

    function automatic int calc_id_width(input int cell_w, input int part_w);
        return 3 * cell_w + part_w;
    endfunction

    function automatic int calc_cnt_width(input int pipes, input int latency);
        return $clog2(pipes * latency + 1);
    endfunction

    function automatic int unsigned popcount(input logic [31:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            n = n + {31'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/rl_force_tag_tracker_if.sv
// Bus between the pair generator / force pipelines and the tag tracker.
//   master : drives pipeline issue, force-valid, buffer status and switch request
//   slave  : the tracker; returns delayed tags, switch grant, counters and errors
interface rl_force_tag_tracker_if
    import rl_md_pkg::*;
#(
    parameter int NUM_PIPES         = 2,
    parameter int CELL_ID_WIDTH     = 3,
    parameter int PARTICLE_ID_WIDTH = 7,
    parameter int PIPE_LATENCY      = 14,
    parameter int ID_WIDTH          = calc_id_width(CELL_ID_WIDTH, PARTICLE_ID_WIDTH),
    parameter int CNT_WIDTH         = calc_cnt_width(NUM_PIPES, PIPE_LATENCY)
);

    logic [NUM_PIPES-1:0]                   in_valid;
    logic [NUM_PIPES*ID_WIDTH-1:0]          in_nb_id;
    logic [NUM_PIPES-1:0]                   force_valid_in;
    logic                                   buffers_empty;
    logic                                   ref_switch_req;
    logic [PARTICLE_ID_WIDTH-1:0]           ref_next_id;

    logic                                   ref_switch_ack;
    logic [PARTICLE_ID_WIDTH-1:0]           active_ref_id;
    logic [NUM_PIPES-1:0]                   out_valid;
    logic [NUM_PIPES*ID_WIDTH-1:0]          out_nb_id;
    logic [NUM_PIPES*PARTICLE_ID_WIDTH-1:0] out_ref_id;
    logic                                   ref_done;
    logic [PARTICLE_ID_WIDTH-1:0]           ref_done_id;
    logic [CNT_WIDTH-1:0]                   inflight;
    logic [NUM_PIPES-1:0]                   align_err;
    logic                                   drain_err;

    modport master (
        output in_valid, in_nb_id, force_valid_in, buffers_empty,
               ref_switch_req, ref_next_id,
        input  ref_switch_ack, active_ref_id, out_valid, out_nb_id, out_ref_id,
               ref_done, ref_done_id, inflight, align_err, drain_err
    );

    modport slave (
        input  in_valid, in_nb_id, force_valid_in, buffers_empty,
               ref_switch_req, ref_next_id,
        output ref_switch_ack, active_ref_id, out_valid, out_nb_id, out_ref_id,
               ref_done, ref_done_id, inflight, align_err, drain_err
    );

endinterface

// File: rtl/rl_tag_delay_line.sv
// Single-pipe tag shift line. A {valid, nb_id, ref_id} entry presented on
// cycle t appears on the outputs on cycle t+PIPE_LATENCY.
//   clk, rst            : clock, synchronous active-high reset
//   i_valid/i_nb_id/i_ref_id : entry sampled every cycle
//   o_valid/o_nb_id/o_ref_id : entry PIPE_LATENCY cycles old
module rl_tag_delay_line #(
    parameter int PIPE_LATENCY = 14,
    parameter int ID_WIDTH     = 16,
    parameter int REF_WIDTH    = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_valid,
    input  logic [ID_WIDTH-1:0]  i_nb_id,
    input  logic [REF_WIDTH-1:0] i_ref_id,
    output logic                 o_valid,
    output logic [ID_WIDTH-1:0]  o_nb_id,
    output logic [REF_WIDTH-1:0] o_ref_id
);

    logic [PIPE_LATENCY-1:0] r_valid;
    logic [ID_WIDTH-1:0]     r_nb_id  [PIPE_LATENCY];
    logic [REF_WIDTH-1:0]    r_ref_id [PIPE_LATENCY];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            for (int s = 0; s < PIPE_LATENCY; s++) begin
                r_nb_id[s]  <= '0;
                r_ref_id[s] <= '0;
            end
        end else begin
            r_valid[0]  <= i_valid;
            r_nb_id[0]  <= i_nb_id;
            r_ref_id[0] <= i_ref_id;
            for (int s = 1; s < PIPE_LATENCY; s++) begin
                r_valid[s]  <= r_valid[s-1];
                r_nb_id[s]  <= r_nb_id[s-1];
                r_ref_id[s] <= r_ref_id[s-1];
            end
        end
    end

    assign o_valid  = r_valid[PIPE_LATENCY-1];
    assign o_nb_id  = r_nb_id[PIPE_LATENCY-1];
    assign o_ref_id = r_ref_id[PIPE_LATENCY-1];

endmodule

// File: rtl/rl_force_tag_tracker.sv
// Tags every pair issued into the NUM_PIPES force pipelines with its neighbour
// ID and the active reference ID, delivers the tag aligned with the force
// output, counts pairs in flight and sequences reference switches with a
// 4-phase req/ack handshake that waits for the pipelines to drain.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of rl_force_tag_tracker_if
//
// state | meaning
// RUN   | tagging with active_ref_id, waiting for a switch request
// DRAIN | request captured; waiting for no pairs in flight or entering and buffers empty
// ACK   | one-cycle grant; active_ref_id takes the captured reference at its end
// REL   | tagging with the new reference, waiting for the request to drop
module rl_force_tag_tracker
    import rl_md_pkg::*;
#(
    parameter int NUM_PIPES         = 2,
    parameter int CELL_ID_WIDTH     = 3,
    parameter int PARTICLE_ID_WIDTH = 7,
    parameter int PIPE_LATENCY      = 14,
    parameter int ID_WIDTH          = calc_id_width(CELL_ID_WIDTH, PARTICLE_ID_WIDTH),
    parameter int CNT_WIDTH         = calc_cnt_width(NUM_PIPES, PIPE_LATENCY)
) (
    input  logic                 clk,
    input  logic                 rst,
    rl_force_tag_tracker_if.slave bus
);

    tag_state_e                             r_state, w_state_nxt;
    logic [PARTICLE_ID_WIDTH-1:0]           r_next_ref, w_next_ref_nxt;
    logic [PARTICLE_ID_WIDTH-1:0]           r_active_ref, w_active_ref_nxt;
    logic                                   r_ack, w_ack_nxt;
    logic [PARTICLE_ID_WIDTH-1:0]           r_done_id, w_done_id_nxt;
    logic [CNT_WIDTH-1:0]                   r_inflight;
    logic [NUM_PIPES-1:0]                   r_align_err;
    logic                                   r_drain_err;

    logic [NUM_PIPES-1:0]                   w_out_valid;
    logic [NUM_PIPES*ID_WIDTH-1:0]          w_out_nb_id;
    logic [NUM_PIPES*PARTICLE_ID_WIDTH-1:0] w_out_ref_id;
    logic [CNT_WIDTH-1:0]                   w_pop_in, w_pop_out;

    for (genvar p = 0; p < NUM_PIPES; p++) begin : g_pipe
        rl_tag_delay_line #(
            .PIPE_LATENCY (PIPE_LATENCY),
            .ID_WIDTH     (ID_WIDTH),
            .REF_WIDTH    (PARTICLE_ID_WIDTH)
        ) u_line (
            .clk      (clk),
            .rst      (rst),
            .i_valid  (bus.in_valid[p]),
            .i_nb_id  (bus.in_nb_id[p*ID_WIDTH +: ID_WIDTH]),
            .i_ref_id (r_active_ref),
            .o_valid  (w_out_valid[p]),
            .o_nb_id  (w_out_nb_id[p*ID_WIDTH +: ID_WIDTH]),
            .o_ref_id (w_out_ref_id[p*PARTICLE_ID_WIDTH +: PARTICLE_ID_WIDTH])
        );
    end

    assign w_pop_in  = CNT_WIDTH'(popcount(32'(bus.in_valid)));
    assign w_pop_out = CNT_WIDTH'(popcount(32'(w_out_valid)));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= RUN;
            r_next_ref   <= '0;
            r_active_ref <= '0;
            r_ack        <= 1'b0;
            r_done_id    <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_next_ref   <= w_next_ref_nxt;
            r_active_ref <= w_active_ref_nxt;
            r_ack        <= w_ack_nxt;
            r_done_id    <= w_done_id_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_next_ref_nxt   = r_next_ref;
        w_active_ref_nxt = r_active_ref;
        case (r_state)
            RUN: begin
                if (bus.ref_switch_req) begin
                    w_next_ref_nxt = bus.ref_next_id;
                    w_state_nxt    = DRAIN;
                end
            end
            DRAIN: begin
                if (r_inflight == '0 && w_pop_in == '0 && bus.buffers_empty)
                    w_state_nxt = ACK;
            end
            ACK: begin
                w_active_ref_nxt = r_next_ref;
                w_state_nxt      = REL;
            end
            REL: begin
                if (!bus.ref_switch_req)
                    w_state_nxt = RUN;
            end
            default: w_state_nxt = RUN;
        endcase
        // Registered decode: the flops hold these values while the state is ACK.
        w_ack_nxt     = (w_state_nxt == ACK);
        w_done_id_nxt = w_ack_nxt ? r_active_ref : '0;
    end

    // Entry and exit in the same cycle cancel; modular arithmetic keeps the
    // intermediate difference harmless.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inflight  <= '0;
            r_align_err <= '0;
            r_drain_err <= 1'b0;
        end else begin
            r_inflight  <= r_inflight + w_pop_in - w_pop_out;
            r_align_err <= r_align_err | (bus.force_valid_in ^ w_out_valid);
            r_drain_err <= r_drain_err | ((r_state == DRAIN) && (|bus.in_valid));
        end
    end

    assign bus.ref_switch_ack = r_ack;
    assign bus.ref_done       = r_ack;
    assign bus.ref_done_id    = r_done_id;
    assign bus.active_ref_id  = r_active_ref;
    assign bus.out_valid      = w_out_valid;
    assign bus.out_nb_id      = w_out_nb_id;
    assign bus.out_ref_id     = w_out_ref_id;
    assign bus.inflight       = r_inflight;
    assign bus.align_err      = r_align_err;
    assign bus.drain_err      = r_drain_err;

endmodule

// File: doc/rl_force_tag_tracker.md
Name: rl_force_tag_tracker

Overview:
Parametrised successor to the fixed neighbour-ID delay line and REF_DELAY timer in the RL force evaluation unit. Sits beside NUM_PIPES parallel RL force pipelines. Each pair entering a pipeline is tagged with its neighbour ID and its reference ID, and the tag is delivered exactly PIPE_LATENCY cycles later, aligned with that pipeline's force output. Reference-particle switching uses a 4-phase req/ack handshake gated by an exact in-flight count, not a fixed cycle timer.

Parameters:
NUM_PIPES, 2, number of parallel force pipelines tracked
CELL_ID_WIDTH, 3, cell coordinate width
PARTICLE_ID_WIDTH, 7, particle index width
ID_WIDTH, 3*CELL_ID_WIDTH+PARTICLE_ID_WIDTH, full neighbour ID width
PIPE_LATENCY, 14, cycles from pipeline input valid to force valid; must be at least 1
CNT_WIDTH, $clog2(NUM_PIPES*PIPE_LATENCY+1), in-flight counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
in_valid  in  NUM_PIPES  pair issued into pipe p this cycle
in_nb_id  in  NUM_PIPES*ID_WIDTH  neighbour ID per pipe
force_valid_in  in  NUM_PIPES  force-valid from each pipeline, used for the alignment check
buffers_empty  in  1  all filter buffers empty (from filter bank)
ref_switch_req  in  1  pair-generator FSM requests next reference, level signal
ref_next_id  in  PARTICLE_ID_WIDTH  next reference ID, valid while req is high
ref_switch_ack  out  1  one-cycle grant
active_ref_id  out  PARTICLE_ID_WIDTH  reference currently used for tagging
out_valid  out  NUM_PIPES  delayed in_valid
out_nb_id  out  NUM_PIPES*ID_WIDTH  delayed neighbour ID
out_ref_id  out  NUM_PIPES*PARTICLE_ID_WIDTH  reference tag travelling with each pair
ref_done  out  1  pulse: every force of the old reference has exited
ref_done_id  out  PARTICLE_ID_WIDTH  reference that completed
inflight  out  CNT_WIDTH  pairs currently inside the pipelines
align_err  out  NUM_PIPES  sticky: force_valid_in[p] != out_valid[p]
drain_err  out  1  sticky: in_valid seen during DRAIN

Behaviour:
- Reset: all outputs, shift stages, counters and sticky bits go to 0; active_ref_id=0; state=RUN. Reset mid-DRAIN discards every in-flight tag and issues no ack.
- Per pipe p: a shift line PIPE_LATENCY deep carrying {valid, nb_id, active_ref_id}, sampled on the in_valid[p] cycle.
  - out_* for p at cycle t+PIPE_LATENCY equal the inputs at cycle t.
  - Stages holding invalid entries present out_valid=0. out_nb_id and out_ref_id are don't-care when out_valid=0.
- inflight register: next value = inflight + popcount(in_valid) − popcount(out_valid), registered. Entry and exit in the same cycle net to zero. It cannot overflow by construction.
- FSM states:
  - RUN: if ref_switch_req=1, capture ref_next_id into next_ref and go to DRAIN.
  - DRAIN: go to ACK when inflight==0, popcount(in_valid)==0 and buffers_empty==1, all in the same cycle. Any in_valid here is still tracked and tagged with the old reference, and sets drain_err.
  - ACK: lasts one cycle. ref_switch_ack=1, ref_done=1, ref_done_id=active_ref_id. active_ref_id takes next_ref at the end of this cycle. Then go to REL.
  - REL: stay until ref_switch_req==0, then go to RUN. In REL, pairs are tagged with the new reference. A req still held high in REL does not start a second switch.
- ref_switch_ack, ref_done and ref_done_id are registered outputs decoded from the ACK state.
- Alignment check: each cycle, align_err[p] is set if force_valid_in[p] != out_valid[p]. It clears only on rst.
- Worst-case ack latency after req = PIPE_LATENCY+2 cycles, given buffers_empty=1 and no new pairs issued.

Decomposition:
- Shared package rl_md_pkg: ID_WIDTH derivation, the FSM state enum {RUN, DRAIN, ACK, REL}, and a popcount function.
- One sub-module, rl_tag_delay_line: a single pipe's valid/nb_id/ref_id shift line, parametrised by PIPE_LATENCY. Instantiate it NUM_PIPES times in a generate loop.

Test Plan:
1. active_ref=5; in_valid[0] at cycle 10 with nb_id 0x0123 -> out_valid[0]=1 at cycle 24 with out_nb_id=0x0123 and out_ref_id=5; inflight=1 during cycles 11–24, then 0.
2. Both pipes valid for 20 consecutive cycles -> inflight climbs to 28, holds, then falls back to 0; no align_err when force_valid_in mirrors out_valid.
3. Switch with 3 pairs in flight and buffers_empty=0, ref_next_id=6 -> no ack until the last exit and buffers_empty=1. Then ack=1 and ref_done=1 with ref_done_id=5, and pairs issued afterward carry out_ref_id=6.
4. in_valid[1] during DRAIN -> drain_err=1; the pair is tagged 5 and delays the ack by a further PIPE_LATENCY cycles.
5. force_valid_in[1] delayed one cycle relative to out_valid[1] -> align_err[1]=1 and stays 1 until rst; align_err[0] stays 0.
6. rst asserted in DRAIN with 10 pairs in flight -> the next cycle shows all outputs 0, state RUN, active_ref_id=0, and no ack is issued.
